dice_match_scorer: RTL and testbench

//  N-player dice match scorer; parametrised successor of the 2-player score keeper.

---
 rtl/dice_pkg.sv | 22 ++
 rtl/btn_edge_sync.sv | 34 +++
 rtl/dice_match_scorer.sv | 180 ++++++++++++++++++
 tb/tb_dice_match_scorer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice match scorer.
//   state_t : match FSM states
//   idx_w   : bit width needed to index/count n items (minimum 1)
//   cnt_w   : window counter width covering the longer of the two windows
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCORE = 2'd1,
    SHOW  = 2'd2,
    FINAL = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int show_cycles, input int final_cycles);
    return idx_w((show_cycles > final_cycles) ? show_cycles : final_cycles);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for one raw player button plus a release detector.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   btn  : raw, asynchronous button level
//   fall : one-cycle pulse when the synchronised button goes 1 -> 0
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift in
      // parallel; blocking ones would collapse the chain into one stage.
      sync_1   <= btn;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
    end
  end

  // Combinational pulse so the arming edge reaches the FSM one cycle sooner.
  assign fall = sync_2_d & ~sync_2;

endmodule

// File: rtl/dice_match_scorer.sv
// N-player dice match scorer.
// Players arm by releasing their start button; when every player is armed a
// round is scored (unique highest die earns +1, saturating). A SHOW window
// follows, at whose end the displayed scores update; if the leader is at least
// WIN_MARGIN ahead of the runner-up a FINAL window announces the winner and
// the match scores clear afterwards.
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   start        : raw player buttons, release arms the player
//   dice         : packed dice, player i at [i*DICE_W +: DICE_W]
//   score        : displayed scores, player i at [i*SCORE_W +: SCORE_W]
//   armed        : per-player armed flags
//   round_active : high during SHOW and FINAL
//   is_final     : high during FINAL
//   finish       : high in the last FINISH_LEAD cycles of SHOW/FINAL
//   winner       : match winner index, valid while is_final
module dice_match_scorer
  import dice_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int DICE_W       = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_MARGIN   = 2,
  parameter int SHOW_CYCLES  = 3_000_000,
  parameter int FINAL_CYCLES = 5_000_000,
  parameter int FINISH_LEAD  = 100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PLAYERS-1:0]           start,
  input  logic [N_PLAYERS*DICE_W-1:0]    dice,
  output logic [N_PLAYERS*SCORE_W-1:0]   score,
  output logic [N_PLAYERS-1:0]           armed,
  output logic                           round_active,
  output logic                           is_final,
  output logic                           finish,
  output logic [idx_w(N_PLAYERS)-1:0]    winner
);

  localparam int IW    = idx_w(N_PLAYERS);
  localparam int CNT_W = cnt_w(SHOW_CYCLES, FINAL_CYCLES);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] FINAL_LAST = CNT_W'(FINAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_FIN   = CNT_W'(SHOW_CYCLES - FINISH_LEAD);
  localparam logic [CNT_W-1:0] FINAL_FIN  = CNT_W'(FINAL_CYCLES - FINISH_LEAD);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  if (FINISH_LEAD >= SHOW_CYCLES || FINISH_LEAD >= FINAL_CYCLES) begin : g_bad_lead
    $error("dice_match_scorer: FINISH_LEAD must be below SHOW_CYCLES and FINAL_CYCLES");
  end
  if (N_PLAYERS < 2 || N_PLAYERS > 8) begin : g_bad_players
    $error("dice_match_scorer: N_PLAYERS must be 2..8");
  end

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]   cnt;
  logic [N_PLAYERS-1:0] fall;
  logic [SCORE_W-1:0] score_int [N_PLAYERS];
  logic [DICE_W-1:0]  die       [N_PLAYERS];

  // Round search results.
  logic [DICE_W-1:0]  die_max;
  logic [IW-1:0]      die_idx;
  logic [3:0]         die_hits;
  // Match search results.
  logic [SCORE_W-1:0] sc_max;
  logic [SCORE_W-1:0] sc_second;
  logic [IW-1:0]      sc_idx;
  logic [SCORE_W-1:0] lead;
  logic               lead_ok;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
    btn_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .btn  (start[i]),
      .fall (fall[i])
    );
    assign die[i] = dice[i*DICE_W +: DICE_W];
  end

  // Highest die, first holder and how many players share it.
  always_comb begin
    die_max  = '0;
    die_idx  = '0;
    die_hits = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (die[i] > die_max) begin
        die_max = die[i];
        die_idx = IW'(i);
      end
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (die[i] == die_max) die_hits = die_hits + 4'd1;
    end
  end

  // Leader, runner-up and lead; a tie at the top yields a zero lead because
  // the second holder of the max becomes the runner-up.
  always_comb begin
    sc_max    = '0;
    sc_idx    = '0;
    sc_second = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (score_int[i] > sc_max) begin
        sc_max = score_int[i];
        sc_idx = IW'(i);
      end
    end
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (IW'(i) != sc_idx && score_int[i] > sc_second) sc_second = score_int[i];
    end
    lead    = sc_max - sc_second;
    lead_ok = 32'(lead) >= 32'(WIN_MARGIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      IDLE:    if (&(armed | fall)) state_next = SCORE;
      SCORE:   state_next = SHOW;
      SHOW:    if (cnt == SHOW_LAST) state_next = lead_ok ? FINAL : IDLE;
      FINAL:   if (cnt == FINAL_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      armed  <= '0;
      score  <= '0;
      winner <= '0;
      // NOTE: the score array is a handful of flops, and a reset must drop any
      // partial match, so it is cleared here rather than left uninitialised.
      for (int i = 0; i < N_PLAYERS; i++) score_int[i] <= '0;
    end else begin
      if (state_next != state) cnt <= '0;
      else if (round_active)   cnt <= cnt + CNT_W'(1);

      unique case (state)
        IDLE: armed <= armed | fall;
        SCORE: begin
          armed <= '0;
          if (die_hits == 4'd1 && score_int[die_idx] != SCORE_MAX)
            score_int[die_idx] <= score_int[die_idx] + SCORE_W'(1);
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            for (int i = 0; i < N_PLAYERS; i++) score[i*SCORE_W +: SCORE_W] <= score_int[i];
            if (lead_ok) winner <= sc_idx;
          end
        end
        FINAL: begin
          if (cnt == FINAL_LAST) begin
            score  <= '0;
            winner <= '0;
            for (int i = 0; i < N_PLAYERS; i++) score_int[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign round_active = (state == SHOW) || (state == FINAL);
  assign is_final     = (state == FINAL);
  assign finish       = ((state == SHOW)  && (cnt >= SHOW_FIN)) ||
                        ((state == FINAL) && (cnt >= FINAL_FIN));

endmodule

// File: tb/tb_dice_match_scorer.sv
// Bench for dice_match_scorer with 3 players and short windows. A second
// instance with an unreachable win margin is used for score saturation.
module tb_dice_match_scorer;

  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sat = 1'b1;
  logic [NP-1:0]   start = '0;
  logic [NP*4-1:0] dice  = '0;
  logic use_sat = 1'b0;

  logic [NP*4-1:0] score_m, score_s;
  logic [NP-1:0]   armed_m, armed_s;
  logic ra_m, ra_s, if_m, if_s, fin_m, fin_s;
  logic [1:0] win_m, win_s;

  logic [NP*4-1:0] score_c;
  logic [NP-1:0]   armed_c;
  logic ra_c, if_c, fin_c;
  logic [1:0] win_c;

  assign score_c = use_sat ? score_s : score_m;
  assign armed_c = use_sat ? armed_s : armed_m;
  assign ra_c    = use_sat ? ra_s    : ra_m;
  assign if_c    = use_sat ? if_s    : if_m;
  assign fin_c   = use_sat ? fin_s   : fin_m;
  assign win_c   = use_sat ? win_s   : win_m;

  dice_match_scorer #(
    .N_PLAYERS(NP), .DICE_W(4), .SCORE_W(4), .WIN_MARGIN(2),
    .SHOW_CYCLES(10), .FINAL_CYCLES(16), .FINISH_LEAD(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dice(dice),
    .score(score_m), .armed(armed_m), .round_active(ra_m),
    .is_final(if_m), .finish(fin_m), .winner(win_m)
  );

  dice_match_scorer #(
    .N_PLAYERS(NP), .DICE_W(4), .SCORE_W(4), .WIN_MARGIN(16),
    .SHOW_CYCLES(10), .FINAL_CYCLES(16), .FINISH_LEAD(2)
  ) dut_sat (
    .clk(clk), .rst(rst_sat), .start(start), .dice(dice),
    .score(score_s), .armed(armed_s), .round_active(ra_s),
    .is_final(if_s), .finish(fin_s), .winner(win_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: internal scores and the score the display should show.
  int ms [NP];
  logic [31:0] disp_exp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) ms[i] = 0;
    disp_exp = '0;
  endtask

  // Press for 3 cycles, then release on a negedge.
  task automatic press_release(input logic [NP-1:0] m);
    start = m;
    repeat (3) @(negedge clk);
    start = '0;
  endtask

  task automatic play_round(input int d0, input int d1, input int d2,
                            input int margin, input bit poke);
    int dv [NP];
    int mx, hits, wi, top, ti, sec, lead;
    bit fin;
    logic [31:0] old_disp;
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    dice = {4'(d2), 4'(d1), 4'(d0)};
    old_disp = disp_exp;
    press_release('1);
    repeat (3) step();
    check("armed_full", 32'(armed_c), 32'd7);
    check("ra_before_latency", 32'(ra_c), 32'd0);
    step();
    check("ra_latency4", 32'(ra_c), 32'd1);
    check("armed_cleared", 32'(armed_c), 32'd0);

    // Unique highest die earns a saturating point.
    mx = -1; hits = 0; wi = 0;
    for (int i = 0; i < NP; i++) if (dv[i] > mx) mx = dv[i];
    for (int i = 0; i < NP; i++) if (dv[i] == mx) begin hits++; wi = i; end
    if (hits == 1 && ms[wi] < 15) ms[wi]++;

    for (int k = 0; k < 10; k++) begin
      check("show_finish", 32'(fin_c), 32'(k >= 8));
      check("show_score_held", 32'(score_c), old_disp);
      check("show_not_final", 32'(if_c), 32'd0);
      if (poke) begin
        check("armed_during_show", 32'(armed_c), 32'd0);
        start[1] = (k >= 2 && k < 5);
      end
      step();
    end

    disp_exp = 32'((ms[2] << 8) | (ms[1] << 4) | ms[0]);
    top = -1; ti = 0; sec = 0;
    for (int i = 0; i < NP; i++) if (ms[i] > top) begin top = ms[i]; ti = i; end
    for (int i = 0; i < NP; i++) if (i != ti && ms[i] > sec) sec = ms[i];
    lead = top - sec;
    fin = (lead >= margin);
    check("score_after_show", 32'(score_c), disp_exp);
    check("is_final_after_show", 32'(if_c), 32'(fin));
    check("ra_after_show", 32'(ra_c), 32'(fin));

    if (fin) begin
      for (int k = 0; k < 16; k++) begin
        check("final_is_final", 32'(if_c), 32'd1);
        check("final_winner", 32'(win_c), 32'(ti));
        check("final_finish", 32'(fin_c), 32'(k >= 14));
        check("final_score", 32'(score_c), disp_exp);
        step();
      end
      model_clear();
      check("post_final_score", 32'(score_c), 32'd0);
      check("post_final_is_final", 32'(if_c), 32'd0);
      check("post_final_ra", 32'(ra_c), 32'd0);
      check("post_final_winner", 32'(win_c), 32'd0);
    end else begin
      check("no_final_winner", 32'(win_c), 32'd0);
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_score", 32'(score_m), 32'd0);
    check("rst_armed", 32'(armed_m), 32'd0);
    check("rst_ra", 32'(ra_m), 32'd0);
    check("rst_is_final", 32'(if_m), 32'd0);
    check("rst_finish", 32'(fin_m), 32'd0);
    check("rst_winner", 32'(win_m), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Unique winner, then a tie, then a second win giving a 2-point lead.
    play_round(5, 3, 2, 2, 1'b0);
    check("first_round_score", 32'(score_m), 32'h001);
    play_round(4, 4, 1, 2, 1'b0);
    check("tie_score_unchanged", 32'(score_m), 32'h001);
    play_round(9, 2, 1, 2, 1'b0);
    check("match_cleared", 32'(score_m), 32'h000);

    // Player 1 toggles during SHOW; those edges must not arm anyone.
    play_round(1, 6, 2, 2, 1'b1);
    check("poke_armed_after", 32'(armed_m), 32'd0);
    press_release(3'b101);
    repeat (6) step();
    check("partial_armed", 32'(armed_m), 32'b101);
    check("partial_no_round", 32'(ra_m), 32'd0);
    play_round(2, 8, 3, 2, 1'b0);

    // Randomised rounds against the model.
    for (int r = 0; r < 10; r++) begin
      play_round(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 2, 1'b0);
    end

    // Reset in the middle of SHOW.
    dice = {4'd1, 4'd1, 4'd6};
    press_release('1);
    repeat (4) step();
    repeat (3) step();
    check("mid_show_active", 32'(ra_m), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_score", 32'(score_m), 32'd0);
    check("abort_armed", 32'(armed_m), 32'd0);
    check("abort_ra", 32'(ra_m), 32'd0);
    check("abort_is_final", 32'(if_m), 32'd0);
    check("abort_finish", 32'(fin_m), 32'd0);
    check("abort_winner", 32'(win_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) step();
    play_round(7, 1, 1, 2, 1'b0);
    check("after_abort_score", 32'(score_m), 32'h001);

    // Saturation on the instance that never reaches FINAL.
    rst = 1'b1;
    rst_sat = 1'b0;
    use_sat = 1'b1;
    model_clear();
    repeat (2) step();
    for (int r = 0; r < 17; r++) play_round(1, 2, 9, 16, 1'b0);
    check("saturated_score", 32'(score_s), 32'hF00);
    check("saturated_not_final", 32'(if_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
